lfsr_gen: RTL

//  Parametrised XNOR Fibonacci LFSR pseudo-random source for the tug-of-war datapath.

---
 rtl/lfsr_gen.sv | 98 +++++++++
 1 files changed

// File: rtl/lfsr_gen.sv
// lfsr_gen: XNOR Fibonacci LFSR pseudo-random source.
//  Run-time seed load, step enable, registered "state > threshold" fire
//  strobe, period measurement between start-state visits, and lock-up flag.
//
// Parameters
//  WIDTH  register width (2..32)
//  TAPS   feedback mask, bit i set = state[i] tapped (even tap count)
//
// Ports
//  clk        clock
//  reset      synchronous, active-high
//  en         advance one step this cycle
//  load       load seed this cycle (wins over en)
//  seed       value loaded on load
//  threshold  compare value for fire (unsigned)
//  state      current LFSR register
//  fire       one-cycle pulse after a step whose new state > threshold
//  wrap       one-cycle pulse after a step that returns state to start
//  period     steps between the last two start-state visits, 0 until first wrap
//  lockup     combinational, state is all-ones
//
// Build option
//  LFSR_LOCKUP_RECOVER_EN: a step taken from all-ones forces state to 0.
//  Without it, all-ones is sticky until load or reset.
module lfsr_gen #(
  parameter int              WIDTH = 9,
  parameter logic [WIDTH-1:0] TAPS = 9'h011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] state,
  output logic             fire,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] cnt_inc;
  logic             fb;

  // XNOR feedback: all-zero is a legal state, all-ones is the stuck state.
  assign fb         = ~(^(state & TAPS));
  assign next_state = {fb, state[WIDTH-1:1]};
  // Saturating increment so non-maximal tap sets never alias the count.
  assign cnt_inc    = (step_cnt == ONES) ? step_cnt : step_cnt + ONE;
  assign lockup     = (state == ONES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= '0;
      start    <= '0;
      step_cnt <= '0;
      period   <= '0;
      fire     <= 1'b0;
      wrap     <= 1'b0;
    end else if (load) begin
      state    <= seed;
      start    <= seed;
      step_cnt <= '0;
      fire     <= 1'b0;
      wrap     <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    end else if (en && lockup) begin
      // Forced escape from the stuck state; restarts period measurement at 0.
      state    <= '0;
      start    <= '0;
      step_cnt <= '0;
      fire     <= 1'b0;
      wrap     <= 1'b0;
`endif
    end else if (en) begin
      state <= next_state;
      fire  <= (next_state > threshold);
      if (next_state == start) begin
        wrap     <= 1'b1;
        period   <= cnt_inc;
        step_cnt <= '0;
      end else begin
        wrap     <= 1'b0;
        step_cnt <= cnt_inc;
      end
    end else begin
      fire <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule
